piso_shifter: RTL and testbench

Parametrised parallel-in/serial-out shift engine for the UART transmit path. It generalises the single-bit mux-plus-flop stage into a complete frame shifter with the following features:
- configurable data width and bit order
- a load handshake
- advancement by an external bit-rate tick
- busy/done status
- an optional parity bit

It sits between the transmit data source and the line driver, which adds start/stop framing around `ser_out`.

---
 rtl/piso_shifter.sv | 103 ++++++++++
 tb/tb_piso_shifter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in/serial-out UART frame shifter; define PISO_PARITY_EN to append a parity bit.
module piso_shifter #(
   parameter int   DATA_W     = 8,
   parameter bit   LSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b1,
   parameter bit   ODD_PARITY = 1'b0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            load_valid,
   output logic                            load_ready,
   input  logic [DATA_W-1:0]               load_data,
   input  logic                            shift_en,
   output logic                            ser_out,
   output logic                            busy,
   output logic                            done,
   output logic [$clog2(DATA_W+2)-1:0]     bit_cnt
);
   localparam int CW = $clog2(DATA_W + 2);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
   logic par_q, par_d;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif
   state_t state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic ser_q, ser_d, done_q, done_d, first, nxt;
   assign first = LSB_FIRST ? load_data[0] : load_data[DATA_W-1];
   assign nxt = LSB_FIRST ? sr_q[1] : sr_q[DATA_W-2];
   assign load_ready = (state_q == IDLE) && rst_n;
   assign busy = state_q != IDLE;
   assign done = done_q;
   assign ser_out = ser_q;
   assign bit_cnt = cnt_q;
   always_comb begin
      state_d = state_q;
      sr_d = sr_q;
      cnt_d = cnt_q;
      ser_d = ser_q;
      done_d = 1'b0;
`ifdef PISO_PARITY_EN
      par_d = par_q;
`endif
      if (state_q == IDLE) begin
         ser_d = IDLE_LEVEL;
         if (load_valid && load_ready) begin
            state_d = SHIFT;
            sr_d = load_data;
            cnt_d = '0;
            ser_d = first;
`ifdef PISO_PARITY_EN
            par_d = first;
`endif
         end
      end else if (shift_en) begin
         if (state_q == SHIFT && cnt_q != LAST) begin
            sr_d = LSB_FIRST ? sr_q >> 1 : sr_q << 1;
            ser_d = nxt;
            cnt_d = cnt_q + 1'b1;
`ifdef PISO_PARITY_EN
            par_d = par_q ^ nxt;
`endif
         end
`ifdef PISO_PARITY_EN
         else if (state_q == SHIFT) begin
            state_d = PARITY;
            ser_d = par_q ^ ODD_PARITY;
            cnt_d = CW'(DATA_W);
         end
`endif
         else begin
            state_d = IDLE;
            ser_d = IDLE_LEVEL;
            cnt_d = '0;
            done_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q <= '0;
         cnt_q <= '0;
         ser_q <= IDLE_LEVEL;
         done_q <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q <= sr_d;
         cnt_q <= cnt_d;
         ser_q <= ser_d;
         done_q <= done_d;
`ifdef PISO_PARITY_EN
         par_q <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: LSB-first (even parity) and MSB-first (odd parity) shifters driven in lockstep against a frame-list model.
module tb_piso_shifter;
   localparam int W = 8;
   localparam int CW = $clog2(W + 2);
`ifdef PISO_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif
   logic clk = 1'b0;
   logic rst_n, load_valid, shift_en;
   logic [W-1:0] load_data;
   logic rdy_l, ser_l, busy_l, done_l, rdy_m, ser_m, busy_m, done_m;
   logic [CW-1:0] cnt_l, cnt_m;
   int tests = 0;
   int fails = 0;
   always #5 clk = ~clk;
   piso_shifter #(.DATA_W(W), .LSB_FIRST(1'b1), .ODD_PARITY(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_l), .load_data(load_data),
      .shift_en(shift_en), .ser_out(ser_l), .busy(busy_l), .done(done_l), .bit_cnt(cnt_l));
   piso_shifter #(.DATA_W(W), .LSB_FIRST(1'b0), .ODD_PARITY(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_m), .load_data(load_data),
      .shift_en(shift_en), .ser_out(ser_m), .busy(busy_m), .done(done_m), .bit_cnt(cnt_m));
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_idle(input string tag, input logic exp_done, input logic exp_rdy);
      chk({tag, " ser_l"}, ser_l, 1'b1);
      chk({tag, " ser_m"}, ser_m, 1'b1);
      chk({tag, " busy"}, {busy_l, busy_m}, 2'b00);
      chk({tag, " done"}, {done_l, done_m}, {exp_done, exp_done});
      chk({tag, " cnt"}, {cnt_l, cnt_m}, '0);
      chk({tag, " ready"}, {rdy_l, rdy_m}, {exp_rdy, exp_rdy});
   endtask
   // Loads d at the current cycle and plays the whole frame; returns in the done cycle.
   task automatic send(input logic [W-1:0] d);
      logic bl [0:W];
      logic bm [0:W];
      for (int i = 0; i < W; i++) begin
         bl[i] = d[i];
         bm[i] = d[W-1-i];
      end
      bl[W] = ^d;
      bm[W] = ~(^d);
      chk("pre-load ready", {rdy_l, rdy_m}, 2'b11);
      load_valid = 1'b1;
      load_data = d;
      shift_en = 1'($urandom_range(0, 1));
      step();
      load_valid = 1'b0;
      load_data = W'($urandom);
      for (int i = 0; i < NB; i++) begin
         shift_en = 1'b0;
         chk($sformatf("bit%0d ser_l", i), ser_l, bl[i]);
         chk($sformatf("bit%0d ser_m", i), ser_m, bm[i]);
         chk($sformatf("bit%0d cnt", i), {cnt_l, cnt_m}, {CW'(i), CW'(i)});
         chk($sformatf("bit%0d busy/done/rdy", i), {busy_l, busy_m, done_l, done_m, rdy_l, rdy_m}, 6'b110000);
         repeat ($urandom_range(0, 2)) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data = W'($urandom);
            step();
            chk($sformatf("hold%0d ser", i), {ser_l, ser_m}, {bl[i], bm[i]});
            chk($sformatf("hold%0d cnt/busy", i), {cnt_l, cnt_m, busy_l, busy_m}, {CW'(i), CW'(i), 2'b11});
         end
         load_valid = 1'b0;
         shift_en = 1'b1;
         step();
      end
      shift_en = 1'b0;
      chk_idle("done cycle", 1'b1, 1'b1);
   endtask
   initial begin
      rst_n = 1'b0;
      load_valid = 1'b0;
      shift_en = 1'b0;
      load_data = '0;
      step();
      step();
      chk("in reset ready", {rdy_l, rdy_m}, 2'b00);
      rst_n = 1'b1;
      step();
      chk_idle("after reset", 1'b0, 1'b1);
      shift_en = 1'b1;
      step();
      shift_en = 1'b0;
      chk_idle("idle tick ignored", 1'b0, 1'b1);
      send(8'h01);
      step();
      chk_idle("post 01", 1'b0, 1'b1);
      send(8'hA5);
      send(8'hFF);
      step();
      chk_idle("post b2b", 1'b0, 1'b1);
      load_valid = 1'b1;
      load_data = 8'h00;
      step();
      load_valid = 1'b0;
      repeat (3) begin
         shift_en = 1'b1;
         step();
      end
      shift_en = 1'b0;
      chk("mid-frame cnt", {cnt_l, cnt_m}, {CW'(3), CW'(3)});
      rst_n = 1'b0;
      step();
      chk_idle("abort reset", 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_idle("abort release", 1'b0, 1'b1);
      for (int f = 0; f < 20; f++) begin
         send(W'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            step();
            chk_idle("gap", 1'b0, 1'b1);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
